// File: rtl/img_line_pkt.sv
// img_line_pkt: packs one RGB565 image line plus an 8-byte header into each UDP packet
module img_line_pkt #(
   parameter logic [15:0] H_PIXEL    = 16'd640,
   parameter logic [15:0] V_PIXEL    = 16'd480,
   parameter logic [31:0] MAGIC      = 32'hF05A_A50F,
   parameter logic [15:0] GAP_CYCLES = 16'd200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] img_data,
   output logic        img_req,
   input  logic        udp_tx_req,
   input  logic        udp_tx_done,
   output logic        udp_tx_start_en,
   output logic [31:0] udp_tx_data,
   output logic [15:0] udp_tx_byte_num,
   output logic [15:0] frame_cnt
);
   localparam logic [15:0] PAIRS   = H_PIXEL >> 1;
   localparam logic [15:0] N_WORDS = PAIRS + 16'd2;
   // the prefetch burst takes 5 cycles from leaving GAP to the start pulse, so GAP is shortened
   // by that much to keep the done-to-start distance at exactly GAP_CYCLES
   localparam logic [15:0] GAP_END = GAP_CYCLES - 16'd5;

   typedef enum logic [2:0] {IDLE, PREFETCH, START, SEND, GAP} state_t;

   state_t      state;
   logic        burst_hi, cap_hi, cap_lo;
   logic [31:0] pix_word, next_word;
   logic [15:0] word_cnt, pair_cnt, gap_cnt, line_idx;
   logic        pix_slot, refill, gap_done, last_line, start_burst;

   assign udp_tx_byte_num = 16'd8 + {H_PIXEL[14:0], 1'b0};

   // word selection and burst triggers for the current state
   always_comb begin
      pix_slot    = (word_cnt >= 16'd2) && (word_cnt < N_WORDS);
      next_word   = (word_cnt == 16'd0) ? MAGIC :
                    (word_cnt == 16'd1) ? {frame_cnt, line_idx} :
                    pix_slot            ? pix_word : 32'd0;
      refill      = (state == SEND) && udp_tx_req && pix_slot && (pair_cnt < PAIRS);
      gap_done    = (state == GAP) && (gap_cnt == GAP_END);
      last_line   = line_idx == V_PIXEL - 16'd1;
      start_burst = ((state == IDLE) && en) || (gap_done && en) || refill;
   end

   // two-cycle read burst; each pixel is captured the cycle after its read enable
   always_ff @(posedge clk) begin
      if (rst) begin
         img_req  <= 1'b0;
         burst_hi <= 1'b0;
         cap_hi   <= 1'b0;
         cap_lo   <= 1'b0;
         pix_word <= 32'd0;
      end else begin
         img_req  <= start_burst | (img_req & burst_hi);
         burst_hi <= start_burst;
         cap_hi   <= img_req & burst_hi;
         cap_lo   <= img_req & ~burst_hi;
         if (cap_hi) pix_word[31:16] <= img_data;
         if (cap_lo) pix_word[15:0] <= img_data;
      end
   end

   // packet sequencing, word output and line/frame bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         udp_tx_start_en <= 1'b0;
         udp_tx_data     <= 32'd0;
         frame_cnt       <= 16'd0;
         line_idx        <= 16'd0;
         word_cnt        <= 16'd0;
         pair_cnt        <= 16'd0;
         gap_cnt         <= 16'd0;
      end else begin
         udp_tx_start_en <= 1'b0;
         case (state)
            IDLE: if (en) begin
               state    <= PREFETCH;
               pair_cnt <= 16'd1;
            end
            PREFETCH: if (cap_lo) begin
               state           <= START;
               udp_tx_start_en <= 1'b1;
            end
            START: begin
               state    <= SEND;
               word_cnt <= 16'd0;
            end
            SEND: begin
               if (udp_tx_req) begin
                  udp_tx_data <= next_word;
                  word_cnt    <= word_cnt + {15'd0, word_cnt < N_WORDS};
               end
               if (refill) pair_cnt <= pair_cnt + 16'd1;
               if (udp_tx_done) begin
                  state   <= GAP;
                  gap_cnt <= 16'd0;
               end
            end
            GAP: if (gap_done) begin
               line_idx  <= last_line ? 16'd0 : line_idx + 16'd1;
               frame_cnt <= last_line ? frame_cnt + 16'd1 : frame_cnt;
               pair_cnt  <= 16'd1;
               state     <= en ? PREFETCH : IDLE;
            end else begin
               gap_cnt <= gap_cnt + 16'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_img_line_pkt.sv
// tb_img_line_pkt: directed checks of the line packetiser with read-FIFO and UDP port models
module tb_img_line_pkt;
   localparam logic [31:0] MAGIC = 32'hF05A_A50F;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst_a = 1'b1, en_a = 1'b0, req_a = 1'b0, done_a = 1'b0;
   logic [15:0] img_data_a = 16'd0;
   logic        img_req_a, start_a;
   logic [31:0] data_a;
   logic [15:0] bn_a, fc_a;

   logic        rst_b = 1'b1, en_b = 1'b0, req_b = 1'b0, done_b = 1'b0;
   logic [15:0] img_data_b = 16'd0;
   logic        img_req_b, start_b;
   logic [31:0] data_b;
   logic [15:0] bn_b, fc_b;

   img_line_pkt #(.H_PIXEL(16'd640), .V_PIXEL(16'd4), .GAP_CYCLES(16'd200)) u_a (
      .clk(clk), .rst(rst_a), .en(en_a), .img_data(img_data_a), .img_req(img_req_a),
      .udp_tx_req(req_a), .udp_tx_done(done_a), .udp_tx_start_en(start_a),
      .udp_tx_data(data_a), .udp_tx_byte_num(bn_a), .frame_cnt(fc_a));

   img_line_pkt #(.H_PIXEL(16'd8), .V_PIXEL(16'd4), .GAP_CYCLES(16'd20)) u_b (
      .clk(clk), .rst(rst_b), .en(en_b), .img_data(img_data_b), .img_req(img_req_b),
      .udp_tx_req(req_b), .udp_tx_done(done_b), .udp_tx_start_en(start_b),
      .udp_tx_data(data_b), .udp_tx_byte_num(bn_b), .frame_cnt(fc_b));

   // read-FIFO models: pixel value is its index within the line, one-cycle read latency
   int idx_a = 0, idx_b = 0, ra = 0, rb = 0, ra0 = 0;
   always @(posedge clk) begin
      if (rst_a) idx_a <= 0;
      else if (img_req_a) begin
         img_data_a <= 16'(idx_a % 640);
         idx_a <= idx_a + 1;
      end
      if (img_req_a) ra <= ra + 1;
   end
   always @(posedge clk) begin
      if (rst_b) idx_b <= 0;
      else if (img_req_b) begin
         img_data_b <= 16'(idx_b % 8);
         idx_b <= idx_b + 1;
      end
      if (img_req_b) rb <= rb + 1;
   end

   int vecs = 0, errs = 0;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      vecs++;
      assert (o === e) else begin
         errs++;
         $error("FAIL %s: observed %08h expected %08h", tag, o, e);
      end
   endtask

   function automatic logic [31:0] exp_word(input int k, input logic [31:0] w1);
      logic [15:0] p;
      p = 16'(2 * (k - 2));
      return (k == 0) ? MAGIC : (k == 1) ? w1 : {p, p + 16'd1};
   endfunction

   task automatic wait_start_a(output int c);
      c = -1;
      for (int i = 0; i < 2000 && c < 0; i++) begin
         @(negedge clk);
         if (start_a) c = cyc;
      end
      if (c < 0) chk("start_a_timeout", 32'd0, 32'd1);
   endtask

   task automatic req_word_a(output logic [31:0] w);
      @(negedge clk) req_a = 1'b1;
      @(negedge clk) req_a = 1'b0;
      w = data_a;
      repeat (6) @(negedge clk);
   endtask

   task automatic done_pulse_a(output int dc);
      @(negedge clk) done_a = 1'b1;
      dc = cyc;
      @(negedge clk) done_a = 1'b0;
      ra0 = ra;
   endtask

   task automatic send_pkt_a(input logic [31:0] w1, input int drop_at, input int rst_at);
      logic [31:0] w;
      for (int k = 0; k < 322; k++) begin
         if (k == drop_at) en_a = 1'b0;
         if (k == rst_at) begin
            @(negedge clk) rst_a = 1'b1;
            @(negedge clk);
            chk("rst_img_req", 32'(img_req_a), 32'd0);
            chk("rst_data", data_a, 32'd0);
            chk("rst_frame_cnt", 32'(fc_a), 32'd0);
            rst_a = 1'b0;
            ra0 = ra;
            return;
         end
         req_word_a(w);
         chk($sformatf("w%0d", k), w, exp_word(k, w1));
         if (k == 1) chk("no_req_in_header", 32'(ra - ra0), 32'd2);
      end
      chk("img_req_per_line", 32'(ra - ra0), 32'd640);
   endtask

   initial begin
      int c, dc, n;
      logic [31:0] w;
      repeat (3) @(negedge clk);
      chk("reset_img_req", 32'(img_req_a), 32'd0);
      chk("reset_start", 32'(start_a), 32'd0);
      chk("reset_data", data_a, 32'd0);
      chk("reset_frame_cnt", 32'(fc_a), 32'd0);
      chk("byte_num_640", 32'(bn_a), 32'd1288);
      rst_a = 1'b0;
      rst_b = 1'b0;
      en_a = 1'b1;
      // line 0: full payload, then stray requests in GAP and the done-to-start distance
      wait_start_a(c);
      send_pkt_a(32'h0000_0000, -1, -1);
      done_pulse_a(dc);
      for (int i = 0; i < 5; i++) begin
         req_word_a(w);
         chk("gap_data_held", w, 32'h027E_027F);
         chk("gap_no_img_req", 32'(ra - ra0), 32'd0);
      end
      wait_start_a(c);
      chk("gap_cycles", 32'(c - dc), 32'd200);
      // lines 1..3, surplus request after the last word of line 3
      send_pkt_a(32'h0000_0001, -1, -1);
      done_pulse_a(dc);
      wait_start_a(c);
      send_pkt_a(32'h0000_0002, -1, -1);
      done_pulse_a(dc);
      wait_start_a(c);
      send_pkt_a(32'h0000_0003, -1, -1);
      req_word_a(w);
      chk("surplus_data", w, 32'd0);
      chk("surplus_no_img_req", 32'(ra - ra0), 32'd640);
      done_pulse_a(dc);
      wait_start_a(c);
      chk("frame_cnt_wrap", 32'(fc_a), 32'd1);
      // line wrap into frame 1, en dropped mid-packet
      send_pkt_a(32'h0001_0000, 100, -1);
      done_pulse_a(dc);
      n = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (start_a) n++;
      end
      chk("idle_no_start", 32'(n), 32'd0);
      chk("idle_no_img_req", 32'(ra - ra0), 32'd0);
      chk("idle_frame_cnt", 32'(fc_a), 32'd1);
      en_a = 1'b1;
      wait_start_a(c);
      send_pkt_a(32'h0001_0001, -1, -1);
      done_pulse_a(dc);
      // reset in the middle of a packet, then restart from line 0 frame 0
      wait_start_a(c);
      send_pkt_a(32'h0001_0002, -1, 50);
      wait_start_a(c);
      send_pkt_a(32'h0000_0000, -1, -1);
      done_pulse_a(dc);
      // short line with requests exactly 8 cycles apart
      chk("byte_num_8", 32'(bn_b), 32'd24);
      en_b = 1'b1;
      c = -1;
      for (int i = 0; i < 200 && c < 0; i++) begin
         @(negedge clk);
         if (start_b) c = cyc;
      end
      if (c < 0) chk("start_b_timeout", 32'd0, 32'd1);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk) req_b = 1'b1;
         @(negedge clk) req_b = 1'b0;
         chk($sformatf("b_w%0d", k), data_b, exp_word(k, 32'd0));
         repeat (6) @(negedge clk);
      end
      chk("b_img_req_total", 32'(rb), 32'd8);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
